// File: rtl/dm_wait_resp.sv
// Multi-cycle data-memory responder with a ready handshake and byte/half/word load-store support.
// Optional misaligned-access flagging is enabled by defining DM_WAIT_ALIGN_CHK_EN.
module dm_wait_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [2:0]  dmtype,
   output logic [31:0] dout,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic accept, finish, req;

   logic [ADDR_W+1:0] addr_eff, addr_q;
   logic [31:0] din_q;
   logic [1:0]  size_c, size_q;
   logic        uns_c, uns_q;
   logic        wr_q;
   logic        mis_c, mis_q;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] mem_word, load_val, store_val;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;
   logic        unused_addr_bits;

   assign req = mem_r | mem_w;
   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   // Size code: 0 word, 1 half, 2 byte; undefined encodings fall back to word.
   always_comb begin
      size_c   = 2'd0;
      uns_c    = 1'b0;
      mis_c    = 1'b0;
      addr_eff = addr[ADDR_W+1:0];
      case (dmtype)
         3'b001: size_c = 2'd1;
         3'b010: begin size_c = 2'd1; uns_c = 1'b1; end
         3'b011: size_c = 2'd2;
         3'b100: begin size_c = 2'd2; uns_c = 1'b1; end
         default: ;
      endcase
`ifdef DM_WAIT_ALIGN_CHK_EN
      mis_c = ((size_c == 2'd0) && (addr[1:0] != 2'b00)) ||
              ((size_c == 2'd1) && addr[0]);
`else
      if (size_c == 2'd0)      addr_eff[1:0] = 2'b00;
      else if (size_c == 2'd1) addr_eff[0]   = 1'b0;
`endif
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: if (req) begin
            accept    = 1'b1;
            cnt_nxt   = LAT;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Dropping the request mid-wait cancels the access without side effects.
            if (!req) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = S_DONE;
               finish    = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= addr_eff;
         din_q  <= din;
         size_q <= size_c;
         uns_q  <= uns_c;
         wr_q   <= mem_w;
         mis_q  <= mis_c;
      end
   end

   assign mem_word = mem[addr_q[ADDR_W+1:2]];

   always_comb begin
      half_sel = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
      case (addr_q[1:0])
         2'b00:   byte_sel = mem_word[7:0];
         2'b01:   byte_sel = mem_word[15:8];
         2'b10:   byte_sel = mem_word[23:16];
         default: byte_sel = mem_word[31:24];
      endcase
      case (size_q)
         2'd1:    load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         2'd2:    load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         default: load_val = mem_word;
      endcase
   end

   // Sub-word stores merge into the current word so untouched lanes survive.
   always_comb begin
      store_val = mem_word;
      case (size_q)
         2'd1: begin
            if (addr_q[1]) store_val[31:16] = din_q[15:0];
            else           store_val[15:0]  = din_q[15:0];
         end
         2'd2: begin
            case (addr_q[1:0])
               2'b00:   store_val[7:0]   = din_q[7:0];
               2'b01:   store_val[15:8]  = din_q[7:0];
               2'b10:   store_val[23:16] = din_q[7:0];
               default: store_val[31:24] = din_q[7:0];
            endcase
         end
         default: store_val = din_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn && finish && wr_q && !mis_q) begin
         mem[addr_q[ADDR_W+1:2]] <= store_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dout <= 32'h0;
      end else if (finish && !wr_q) begin
         dout <= mis_q ? 32'h0 : load_val;
      end
   end

   assign ready = (state == S_DONE);
   assign busy  = (state != S_IDLE);
`ifdef DM_WAIT_ALIGN_CHK_EN
   assign err   = (state == S_DONE) && mis_q;
`else
   assign err   = 1'b0;
`endif

endmodule
